// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: packs camera byte pairs into RGB565 pixels
// with linear write addresses and reports per-frame completion status.
module ov7670_capture #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        we_out,
  output logic [16:0] wAddr_out,
  output logic [15:0] wData_out,
  output logic        frame_done,
  output logic        frame_err
);

  // Frame size must fit the 17-bit pixel counter (at most 131071 pixels).
  localparam logic [16:0] PIX_TOTAL = 17'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [16:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT_VS_HI,
    WAIT_VS_LO,
    CAPTURE
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] cnt_q,   cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q,    hi_d;
  logic        we_q,    we_d;
  logic [16:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  // NOTE: every state bit is reset here, including the held pixel bus and the
  // latched high byte, so nothing is X after reset; non-blocking (<=) keeps all
  // registers updating from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_VS_HI;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every _d gets a default before the case so no path infers a latch;
  // strobes default low, held values default to their current register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      WAIT_VS_HI: begin
        if (vsync) state_d = WAIT_VS_LO;
      end

      WAIT_VS_LO: begin
        if (!vsync) begin
          if (capture_en) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            state_d = WAIT_VS_HI;
          end
        end
      end

      CAPTURE: begin
        // vsync wins over href: a half-received pixel at frame end is dropped.
        if (vsync) begin
          done_d  = 1'b1;
          err_d   = (cnt_q != PIX_TOTAL);
          phase_d = 1'b0;
          state_d = WAIT_VS_LO;
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (cnt_q < PIX_TOTAL) begin
              we_d    = 1'b1;
              waddr_d = cnt_q;
              wdata_d = {hi_q, data};
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 17'd1;
          end
        end else begin
          phase_d = 1'b0;
        end
      end

      default: state_d = WAIT_VS_HI;
    endcase
  end

  assign we_out     = we_q;
  assign wAddr_out  = waddr_q;
  assign wData_out  = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a small 8x4 frame: a byte-level
// camera model queues expected writes/frame results, a monitor pops them.
module tb_ov7670_capture;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int TOTAL = W * H;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        we_out;
  logic [16:0] wAddr_out;
  logic [15:0] wData_out;
  logic        frame_done;
  logic        frame_err;

  ov7670_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .we_out     (we_out),
    .wAddr_out  (wAddr_out),
    .wData_out  (wData_out),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] pix;
  } wr_t;

  wr_t  exp_q[$];
  bit   err_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Camera-side model state.
  bit         capturing = 0;
  bit         phase     = 0;
  bit         pack_mode = 0;
  int         cnt       = 0;
  logic [7:0] hi        = '0;
  int         n_push    = 0;
  int         n_done_exp = 0;

  // Monitor-side bookkeeping.
  int          wr_seen   = 0;
  int          done_seen = 0;
  logic [16:0] last_addr = '0;
  logic [15:0] last_pix  = '0;
  logic        last_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: every strobe must match the head of the queue; between strobes
  // the bus and frame_err must hold their last values.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (we_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", we_out, 1'b0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("waddr", wAddr_out, e.addr);
          check("wdata", wData_out, e.pix);
          last_addr = e.addr;
          last_pix  = e.pix;
          wr_seen++;
        end
      end else begin
        check("hold_addr", wAddr_out, last_addr);
        check("hold_data", wData_out, last_pix);
      end
      if (frame_done) begin
        if (err_q.size() == 0) begin
          check("unexpected_done", frame_done, 1'b0);
        end else begin
          bit e;
          e = err_q.pop_front();
          check("frame_err", frame_err, e);
          last_err = e;
          done_seen++;
        end
      end else begin
        check("err_hold", frame_err, last_err);
      end
    end
  end

  task automatic send_bytes(input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] v;
      bit         first_pix;
      @(negedge clk);
      first_pix = pack_mode && capturing && (cnt == 0);
      v = 8'($urandom);
      if (first_pix) v = phase ? 8'h1F : 8'hF8;
      href = 1'b1;
      data = v;
      if (!phase) begin
        hi    = v;
        phase = 1'b1;
        if (first_pix) begin
          @(posedge clk); #1;
          check("pack_no_we_early", we_out, 1'b0);
        end
      end else begin
        phase = 1'b0;
        if (capturing) begin
          if (cnt < TOTAL) begin
            exp_q.push_back('{addr: 17'(cnt), pix: {hi, v}});
            n_push++;
          end
          if (first_pix) begin
            @(posedge clk); #1;
            check("pack_we", we_out, 1'b1);
            check("pack_addr", wAddr_out, 17'd0);
            check("pack_data", wData_out, 16'hF81F);
          end
          cnt++;
        end
      end
    end
  endtask

  // One frame: vsync pulse, blanking, lines, closing vsync rise.
  // odd_line gets one extra trailing byte; flip_en toggles capture_en
  // after the vsync fall; vs_href makes vsync rise together with href.
  task automatic run_frame(input int lines, input int odd_line, input bit en,
                           input bit flip_en, input bit vs_href);
    @(negedge clk);
    vsync = 1'b1; href = 1'b0; capture_en = en;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    capturing = en; cnt = 0; phase = 0;
    repeat (2) @(negedge clk);
    if (flip_en) capture_en = ~en;
    for (int l = 0; l < lines; l++) begin
      send_bytes((l == odd_line) ? 2 * W + 1 : 2 * W);
      @(negedge clk);
      href  = 1'b0;
      phase = 0;
      @(negedge clk);
    end
    if (vs_href) send_bytes(1);
    @(negedge clk);
    vsync = 1'b1; href = vs_href; data = 8'hA5;
    if (capturing) begin
      err_q.push_back(cnt != TOTAL);
      n_done_exp++;
    end
    capturing = 0; phase = 0;
    repeat (3) @(negedge clk);
    href = 1'b0;
    check("frame_writes", wr_seen, n_push);
    check("frame_dones", done_seen, n_done_exp);
  endtask

  initial begin
    int wr0;
    reset = 1'b0; capture_en = 1'b0; vsync = 1'b0; href = 1'b0; data = '0;
    #3;
    check("rst_we", we_out, 1'b0);
    check("rst_addr", wAddr_out, 17'd0);
    check("rst_data", wData_out, 16'd0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", frame_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    pack_mode = 1;
    run_frame(H, -1, 1'b1, 1'b0, 1'b0);   // full frame, first pixel F8/1F
    pack_mode = 0;
    run_frame(H, 1, 1'b1, 1'b1, 1'b0);    // odd line, capture_en dropped mid-frame
    run_frame(H - 1, -1, 1'b1, 1'b0, 1'b1); // short frame, vsync rises with href
    run_frame(H + 1, -1, 1'b1, 1'b0, 1'b0); // long frame, writes stop at TOTAL-1
    run_frame(H, -1, 1'b0, 1'b1, 1'b0);   // skipped, enable raised mid-frame
    run_frame(H, -1, 1'b1, 1'b0, 1'b0);   // captured again next frame

    // Reset in the middle of a line.
    @(negedge clk);
    vsync = 1'b1; capture_en = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0; capturing = 1; cnt = 0; phase = 0;
    repeat (2) @(negedge clk);
    send_bytes(5);
    @(negedge clk); #2;
    reset = 1'b0;
    capturing = 0; phase = 0;
    last_addr = '0; last_pix = '0; last_err = 1'b0;
    #1;
    check("mid_rst_we", we_out, 1'b0);
    check("mid_rst_addr", wAddr_out, 17'd0);
    check("mid_rst_data", wData_out, 16'd0);
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_err", frame_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wr0 = wr_seen;
    send_bytes(10);
    @(negedge clk);
    href = 1'b0;
    repeat (3) @(negedge clk);
    check("no_wr_after_rst", wr_seen - wr0, 0);
    run_frame(H, -1, 1'b1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("wr_queue_empty", exp_q.size(), 0);
    check("done_queue_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 SHALL have port clk  input  1  camera pixel clock (PCLK); the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port capture_en  input  1  frame-level capture enable, sampled only at frame start.
REQ-006 SHALL have port vsync  input  1  camera VSYNC, high = vertical blanking.
REQ-007 SHALL have port href  input  1  camera HREF, high = valid byte on data.
REQ-008 SHALL have port data  input  8  camera byte bus.
REQ-009 SHALL have port we_out  output  1  one-cycle pixel write strobe to the filter stage's we_in.
REQ-010 SHALL have port wAddr_out  output  17  linear pixel address, row*IMG_WIDTH+col.
REQ-011 SHALL have port wData_out  output  16  RGB565 pixel, first byte in [15:8].
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-013 SHALL have port frame_err  output  1  valid with frame_done; high if pixel count != IMG_WIDTH*IMG_HEIGHT.

Function
REQ-014 SHALL implement FSM states WAIT_VS_HI, WAIT_VS_LO, CAPTURE.
REQ-015 SHALL transition WAIT_VS_HI -> WAIT_VS_LO on sampled vsync=1.
REQ-016 SHALL, in WAIT_VS_LO on sampled vsync=0, go to CAPTURE if capture_en=1, else return to WAIT_VS_HI (frame skipped, no outputs).
REQ-017 SHALL, on entering CAPTURE, clear pixel counter and byte phase to 0.
REQ-018 SHALL, in CAPTURE with href=1 and phase=0, latch data as high byte and set phase=1.
REQ-019 SHALL, in CAPTURE with href=1 and phase=1, register wData_out={high byte, data}, wAddr_out=pixel counter, we_out=1, increment pixel counter, set phase=0.
REQ-020 SHALL produce we_out high for exactly the one cycle after the second byte is sampled (latency 1 clk from second byte); we_out=0 in every other cycle.
REQ-021 SHALL hold wAddr_out and wData_out at last written values when we_out=0.
REQ-022 SHALL, on sampled href=0 with phase=1 (odd byte count in line), discard the partial byte and reset phase to 0 without a write.
REQ-023 SHALL suppress we_out (counter still increments, saturating at 2^17-1) once pixel counter >= IMG_WIDTH*IMG_HEIGHT.
REQ-024 SHALL, in CAPTURE on sampled vsync=1, pulse frame_done for one cycle, set frame_err=(pixel counter != IMG_WIDTH*IMG_HEIGHT), and go to WAIT_VS_LO.
REQ-025 SHALL hold frame_err stable until the next frame_done; frame_done=0 otherwise.
REQ-026 SHALL give vsync priority over href when both sampled high in CAPTURE (no write in that cycle, partial byte discarded).
REQ-027 SHALL ignore capture_en changes while in CAPTURE; the current frame completes.
REQ-028 SHALL size the pixel counter 17 bits; IMG_WIDTH*IMG_HEIGHT SHALL not exceed 131071.

Reset
REQ-029 SHALL, on reset=0 at any time, asynchronously force state WAIT_VS_HI, we_out=0, wAddr_out=0, wData_out=0, frame_done=0, frame_err=0, pixel counter=0, phase=0.
REQ-030 SHALL, after reset release mid-frame, write nothing until a full vsync high-then-low sequence is seen.

Verification
REQ-031 Full frame: capture_en=1, vsync pulse, 240 lines of 640 bytes, vsync rise -> 76800 we_out pulses, addresses 0..76799 in order, frame_done=1 with frame_err=0.
REQ-032 Byte pack: bytes 0xF8,0x1F as first pixel -> we_out one cycle after 0x1F sampled, wAddr_out=0, wData_out=0xF81F.
REQ-033 Odd line: one line of 641 bytes -> 320 writes for that line, trailing byte dropped, next line starts at phase 0 with contiguous addresses.
REQ-034 Short/long frame: 239 lines -> frame_done with frame_err=1; 241 lines -> writes stop after address 76799, frame_err=1.
REQ-035 Enable gating: capture_en=0 at vsync fall -> no we_out or frame_done for that frame; capture_en raised mid-frame -> capture starts only at next frame.
REQ-036 Reset mid-line: reset=0 during CAPTURE -> all outputs 0 immediately; after release, data with href=1 before a vsync cycle produces no writes.
